tx_frame_sequencer: RTL and testbench

Frame-level controller for the 802.11a transmit chain: accepts a frame request with a PSDU length, pulses the transmitter's one-shot start, and waits out the preamble, SIGNAL and SERVICE fields. It then streams the PSDU bits, 6 tail zeros and pad zeros to the transmitter's data input so the DATA field fills a whole number of OFDM symbols. It sits between the MAC-side byte source and the serial transmitter.

---
 rtl/tx_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// Frame-level controller for the 802.11a transmitter: pulses start, waits out the header
// fields, then streams PSDU bits LSB first, six tail zeros and pad zeros to a symbol boundary.
module tx_frame_sequencer #(
  parameter int HEADER_CYCLES = 139,
  parameter int N_DBPS        = 24,
  parameter int MAX_LENGTH    = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        request_i,
  input  logic [11:0] length_i,
  output logic        busy_o,
  output logic        start_o,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        data_bit_o,
  output logic        data_valid_o,
  output logic        done_o,
  output logic        error_o,
  output logic        underrun_o
);
  typedef enum logic [2:0] {IDLE, START, HEADER, DATA, TAIL, PAD, DONE} state_t;

  localparam logic [7:0]  HdrLast = 8'(HEADER_CYCLES - 2);
  localparam logic [7:0]  CWrap   = 8'(N_DBPS - 1);
  localparam logic [7:0]  CInit   = 8'(16 % N_DBPS);
  localparam logic [12:0] MaxLen  = 13'(MAX_LENGTH);

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] fetched_q, fetched_d;
  logic [11:0] sent_q, sent_d;
  logic [7:0]  hdr_cnt_q, hdr_cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  tail_q, tail_d;
  logic [7:0]  c_q, c_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        underrun_q, underrun_d;
  logic        error_q, error_d;

  logic        len_ok;
  logic        reload;
  logic        xfer;
  logic [7:0]  c_inc;

  assign len_ok = (length_i != 12'd0) && ({1'b0, length_i} <= MaxLen);
  assign reload = (state_q == DATA) && (bit_q == 3'd0);
  assign c_inc  = (c_q == CWrap) ? 8'd0 : c_q + 8'd1;

  // The reload cycle is excluded so a late byte can never land on a slot already substituted.
  assign byte_ready_o = ((state_q == HEADER) || ((state_q == DATA) && (bit_q != 3'd0)))
                        && !buf_full_q && (fetched_q < len_q);
  assign xfer = byte_ready_o && byte_valid_i;

  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign start_o      = (state_q == START);
  assign done_o       = (state_q == DONE);
  assign data_valid_o = (state_q == DATA) || (state_q == TAIL) || (state_q == PAD);
  assign error_o      = error_q;
  assign underrun_o   = underrun_q;

  // Bit 0 of each byte comes straight from the holding register; an empty buffer reads as zero.
  always_comb begin
    data_bit_o = 1'b0;
    if (state_q == DATA) begin
      if (bit_q == 3'd0) data_bit_o = buf_full_q & buf_q[0];
      else               data_bit_o = sh_q[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    fetched_d  = fetched_q;
    sent_d     = sent_q;
    hdr_cnt_d  = hdr_cnt_q;
    bit_d      = bit_q;
    tail_d     = tail_q;
    c_d        = c_q;
    sh_d       = sh_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = underrun_q;
    error_d    = 1'b0;

    if (xfer) begin
      buf_d      = byte_i;
      buf_full_d = 1'b1;
      fetched_d  = fetched_q + 12'd1;
    end

    case (state_q)
      IDLE: begin
        if (request_i) begin
          if (len_ok) begin
            state_d    = START;
            len_d      = length_i;
            fetched_d  = 12'd0;
            sent_d     = 12'd0;
            buf_full_d = 1'b0;
            underrun_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      START: begin
        state_d   = HEADER;
        hdr_cnt_d = 8'd0;
        bit_d     = 3'd0;
        tail_d    = 3'd0;
        c_d       = CInit;
      end
      HEADER: begin
        if (hdr_cnt_q == HdrLast) state_d = DATA;
        else                      hdr_cnt_d = hdr_cnt_q + 8'd1;
      end
      DATA: begin
        c_d   = c_inc;
        bit_d = bit_q + 3'd1;
        if (reload) begin
          if (buf_full_q) begin
            sh_d       = buf_q[7:1];
            buf_full_d = 1'b0;
          end else begin
            // Missing byte: send zeros in its slot and keep frame timing intact.
            sh_d       = 7'd0;
            underrun_d = 1'b1;
            fetched_d  = fetched_q + 12'd1;
          end
        end else begin
          sh_d = {1'b0, sh_q[6:1]};
        end
        if (bit_q == 3'd7) begin
          sent_d = sent_q + 12'd1;
          if (sent_q == len_q - 12'd1) state_d = TAIL;
        end
      end
      TAIL: begin
        c_d    = c_inc;
        tail_d = tail_q + 3'd1;
        if (tail_q == 3'd5) state_d = (c_inc == 8'd0) ? DONE : PAD;
      end
      PAD: begin
        c_d = c_inc;
        if (c_q == CWrap) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= 12'd0;
      fetched_q  <= 12'd0;
      sent_q     <= 12'd0;
      hdr_cnt_q  <= 8'd0;
      bit_q      <= 3'd0;
      tail_q     <= 3'd0;
      c_q        <= 8'd0;
      sh_q       <= 7'd0;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fetched_q  <= fetched_d;
      sent_q     <= sent_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bit_q      <= bit_d;
      tail_q     <= tail_d;
      c_q        <= c_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: two instances (6 Mbps defaults and N_DBPS=30 with a
// short header and MAX_LENGTH=100) driven by a shared byte source; all expectations hand-derived.
`timescale 1ns/1ps
module tb_tx_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req24 = 1'b0;
  logic        req30 = 1'b0;
  logic [11:0] length = 12'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;

  logic busy24, start24, ready24, dbit24, dval24, done24, err24, und24;
  logic busy30, start30, ready30, dbit30, dval30, done30, err30, und30;
  logic busy, start, ready, dbit, dval, done, err, und;

  int sel = 0;
  int n_checks = 0;
  int n_pass = 0;
  int src_idx = 0;
  int src_len = 0;
  int hold_idx = -1;
  logic xfer_prev = 1'b0;

  logic [7:0] tbl [16] = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'hFF, 8'h3C, 8'h96, 8'h27,
                           8'hE1, 8'h4D, 8'hB8, 8'h72, 8'h0F, 8'hA5, 8'h69, 8'hD4};

  always #5 clk = ~clk;

  tx_frame_sequencer dut (
    .clk_i(clk), .rst_i(rst), .request_i(req24), .length_i(length),
    .busy_o(busy24), .start_o(start24), .byte_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(ready24), .data_bit_o(dbit24), .data_valid_o(dval24),
    .done_o(done24), .error_o(err24), .underrun_o(und24)
  );

  tx_frame_sequencer #(.HEADER_CYCLES(40), .N_DBPS(30), .MAX_LENGTH(100)) dut30 (
    .clk_i(clk), .rst_i(rst), .request_i(req30), .length_i(length),
    .busy_o(busy30), .start_o(start30), .byte_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(ready30), .data_bit_o(dbit30), .data_valid_o(dval30),
    .done_o(done30), .error_o(err30), .underrun_o(und30)
  );

  assign busy  = (sel != 0) ? busy30  : busy24;
  assign start = (sel != 0) ? start30 : start24;
  assign ready = (sel != 0) ? ready30 : ready24;
  assign dbit  = (sel != 0) ? dbit30  : dbit24;
  assign dval  = (sel != 0) ? dval30  : dval24;
  assign done  = (sel != 0) ? done30  : done24;
  assign err   = (sel != 0) ? err30   : err24;
  assign und   = (sel != 0) ? und30   : und24;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Byte source: offers table bytes in order; a held slot is never offered and is
  // skipped once the DUT flags the underrun.
  initial begin
    forever begin
      @(negedge clk);
      if (xfer_prev) src_idx++;
      if (src_idx == hold_idx && und) src_idx++;
      byte_valid = (src_idx < src_len) && (src_idx != hold_idx);
      byte_in    = tbl[src_idx % 16];
      xfer_prev  = byte_valid && ready;
    end
  end

  task automatic set_req(input int s, input logic v);
    if (s != 0) req30 = v;
    else        req24 = v;
  endtask

  task automatic run_frame(input int s, input int len, input int hold, input int hc,
                           input int exp_done, input int exp_und, input int abort_at,
                           input int stray_at);
    int first, nval, bad_bits, done_at, start_cnt, busy_gap, err_cnt, done_dval, done_busy;
    logic [7:0] b;
    logic eb;
    sel = s;
    src_idx = 0; src_len = len; hold_idx = hold; xfer_prev = 1'b0;
    @(negedge clk);
    set_req(s, 1'b1); length = 12'(len);
    @(negedge clk);
    set_req(s, 1'b0);
    check("start_at_k", start, 1);
    check("busy_at_k", busy, 1);
    check("underrun_cleared", und, 0);
    first = -1; nval = 0; bad_bits = 0; done_at = -1; start_cnt = 0;
    busy_gap = 0; err_cnt = 0; done_dval = 0; done_busy = 0;
    for (int cyc = 1; cyc < 5000 && done_at < 0; cyc++) begin
      @(negedge clk);
      set_req(s, cyc == stray_at);
      if (cyc == stray_at) length = 12'd0;
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_dval", dval, 0);
        check("rst_dbit", dbit, 0);
        check("rst_ready", ready, 0);
        check("rst_start", start, 0);
        check("rst_done", done, 0);
        check("rst_underrun", und, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("frame len=%0d aborted by reset at k+%0d", len, cyc);
        return;
      end
      if (start) start_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_at = cyc; done_dval = dval; done_busy = busy;
      end else begin
        if (!busy) busy_gap++;
        if (dval) begin
          if (first < 0) first = cyc;
          eb = 1'b0;
          if (nval < 8 * len) begin
            b  = (nval / 8 == hold) ? 8'h00 : tbl[(nval / 8) % 16];
            eb = b[nval % 8];
          end
          if (dbit !== eb) bad_bits++;
          nval++;
        end
      end
    end
    check("first_psdu_cycle", first, hc);
    check("data_valid_bits", nval, exp_done - hc);
    check("bit_errors", bad_bits, 0);
    check("done_cycle", done_at, exp_done);
    check("extra_start", start_cnt, 0);
    check("busy_gap", busy_gap, 0);
    check("error_in_frame", err_cnt, 0);
    check("done_dval", done_dval, 0);
    check("done_busy", done_busy, 0);
    check("underrun_end", und, exp_und);
    @(negedge clk);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    $display("frame len=%0d ndbps=%0d done_at=k+%0d bits=%0d underrun=%0d",
             len, (s != 0) ? 30 : 24, done_at, nval, und);
  endtask

  task automatic bad_req(input int s, input int len);
    sel = s;
    @(negedge clk);
    set_req(s, 1'b1); length = 12'(len);
    @(negedge clk);
    set_req(s, 1'b0);
    check("err_pulse", err, 1);
    check("err_no_start", start, 0);
    check("err_no_busy", busy, 0);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_still_idle", busy, 0);
    $display("refused request len=%0d", len);
  endtask

  initial begin
    @(negedge clk);
    check("reset_busy", busy24, 0);
    check("reset_start", start24, 0);
    check("reset_dval", dval24, 0);
    check("reset_ready", ready24, 0);
    check("reset_error", err24, 0);
    check("reset_underrun", und24, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 16, -1, 139, 291, 0, -1, -1);
    run_frame(0, 3,  -1, 139, 171, 0, -1, -1);
    run_frame(1, 1,  -1, 40,  54,  0, -1, -1);
    run_frame(1, 100, -1, 40, 864, 0, -1, -1);
    bad_req(0, 0);
    bad_req(1, 101);
    run_frame(0, 4, 2, 139, 195, 1, -1, -1);
    repeat (3) @(negedge clk);
    check("underrun_sticky", und24, 1);
    run_frame(0, 8, -1, 139, 0, 0, 159, -1);
    run_frame(0, 2, -1, 139, 171, 0, -1, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
